// File: rtl/uf_pkg.sv
// rtl/uf_pkg.sv - shared types and constants for the union-find line BRAM readers
package uf_pkg;

  localparam int UF_ADDR_W = 9;
  localparam int UF_ROW_W  = 1280;

  // Requester IDs carried in the read tag
  localparam int UF_REQ_UF  = 0;
  localparam int UF_REQ_AUX = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2
  } uf_arb_state_e;

endpackage

// File: rtl/uf_rd_tag_pipe.sv
// rtl/uf_rd_tag_pipe.sv - fixed-depth {valid, id} tag delay line matching BRAM read latency
module uf_rd_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [ID_W-1:0] id_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  logic [DEPTH-1:0] vld_q;
  logic [ID_W-1:0]  id_q [DEPTH];

  // Shift the tag one stage per cycle; clear drops every read still in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        id_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= valid_i;
      id_q[0]  <= id_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign id_o    = id_q[DEPTH-1];

endmodule

// File: rtl/uf_bram_arb.sv
// rtl/uf_bram_arb.sv - two-requester read arbiter and return sequencer for the thresholded line BRAM
module uf_bram_arb
  import uf_pkg::*;
#(
  parameter int ADDR_W     = UF_ADDR_W,
  parameter int DATA_W     = UF_ROW_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_bram_ready,
  output logic              o_enb,
  output logic [ADDR_W-1:0] o_addrb,
  input  logic [DATA_W-1:0] i_doutb,
  input  logic              i_r0_req,
  input  logic [ADDR_W-1:0] i_r0_addr,
  output logic              o_r0_gnt,
  output logic              o_r0_rvalid,
  input  logic              i_r1_req,
  input  logic [ADDR_W-1:0] i_r1_addr,
  output logic              o_r1_gnt,
  output logic              o_r1_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  uf_arb_state_e   state_q;
  logic [SC_W-1:0] starve_q;
  logic [2:0]      infl_q;

  logic arb_en;
  logic r1_force;
  logic gnt0;
  logic gnt1;
  logic tag_vld;
  logic tag_id;

  // Fixed priority to the union-find engine unless the aux reader has waited STARVE_MAX cycles
  always_comb begin
    arb_en   = (state_q == ST_SERVE) && i_bram_ready;
    r1_force = (starve_q == SC_W'(STARVE_MAX));
    gnt1     = arb_en && i_r1_req && (r1_force || !i_r0_req);
    gnt0     = arb_en && i_r0_req && !gnt1;
  end

  assign o_r0_gnt = gnt0;
  assign o_r1_gnt = gnt1;
  assign o_enb    = gnt0 | gnt1;
  assign o_addrb  = gnt1 ? i_r1_addr : (gnt0 ? i_r0_addr : '0);

  // Tag each issued read so the returning row is steered to its owner
  uf_rd_tag_pipe #(
    .DEPTH (RD_LAT),
    .ID_W  (1)
  ) u_tag_pipe (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (o_enb),
    .id_i    (gnt1 ? 1'(UF_REQ_AUX) : 1'(UF_REQ_UF)),
    .valid_o (tag_vld),
    .id_o    (tag_id)
  );

  assign o_r0_rvalid = tag_vld && (tag_id == 1'(UF_REQ_UF));
  assign o_r1_rvalid = tag_vld && (tag_id == 1'(UF_REQ_AUX));
  assign o_rdata     = i_doutb;
  assign o_busy      = (state_q != ST_IDLE);

  // Count consecutive denied aux cycles; any cycle without a pending denied request resets it
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (arb_en && i_r1_req && !gnt1) begin
      starve_q <= starve_q + SC_W'(1);
    end else begin
      starve_q <= '0;
    end
  end

  // Reads issued but not yet returned; a simultaneous issue and return leaves it unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_q <= 3'd0;
    end else begin
      case ({o_enb, tag_vld})
        2'b10:   infl_q <= infl_q + 3'd1;
        2'b01:   infl_q <= infl_q - 3'd1;
        default: infl_q <= infl_q;
      endcase
    end
  end

  // Serve only while the frame is ready, and drain outstanding reads before going idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (i_bram_ready) state_q <= ST_SERVE;
        ST_SERVE: if (!i_bram_ready) state_q <= ST_DRAIN;
        ST_DRAIN: if (infl_q == 3'd0) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uf_bram_arb.sv
// tb/tb_uf_bram_arb.sv - directed and latency-sweep bench for uf_bram_arb
module tb_uf_bram_arb;

  localparam int AW = 9;
  localparam int DW = 1280;

  logic clk;
  logic rst;

  // Main instance, RD_LAT = 2
  logic          ready;
  logic          enb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic          r0_req, r1_req;
  logic [AW-1:0] r0_addr, r1_addr;
  logic          r0_gnt, r1_gnt, r0_rv, r1_rv;
  logic [DW-1:0] rdata;
  logic          busy;

  // Sweep instances share request inputs, differ only in latency
  logic          sw_ready;
  logic          sw_r0_req, sw_r1_req;
  logic [AW-1:0] sw_r0_addr, sw_r1_addr;
  logic [DW-1:0] zero_row;
  logic          l1_enb, l1_g0, l1_g1, l1_rv0, l1_rv1, l1_busy;
  logic [AW-1:0] l1_addrb;
  logic [DW-1:0] l1_rdata;
  logic          l4_enb, l4_g0, l4_g1, l4_rv0, l4_rv1, l4_busy;
  logic [AW-1:0] l4_addrb;
  logic [DW-1:0] l4_rdata;

  int n_chk = 0;
  int n_err = 0;

  uf_bram_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_MAX(8)) u_dut (
    .clk(clk), .rst(rst), .i_bram_ready(ready), .o_enb(enb), .o_addrb(addrb), .i_doutb(doutb),
    .i_r0_req(r0_req), .i_r0_addr(r0_addr), .o_r0_gnt(r0_gnt), .o_r0_rvalid(r0_rv),
    .i_r1_req(r1_req), .i_r1_addr(r1_addr), .o_r1_gnt(r1_gnt), .o_r1_rvalid(r1_rv),
    .o_rdata(rdata), .o_busy(busy)
  );

  uf_bram_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(8)) u_l1 (
    .clk(clk), .rst(rst), .i_bram_ready(sw_ready), .o_enb(l1_enb), .o_addrb(l1_addrb), .i_doutb(zero_row),
    .i_r0_req(sw_r0_req), .i_r0_addr(sw_r0_addr), .o_r0_gnt(l1_g0), .o_r0_rvalid(l1_rv0),
    .i_r1_req(sw_r1_req), .i_r1_addr(sw_r1_addr), .o_r1_gnt(l1_g1), .o_r1_rvalid(l1_rv1),
    .o_rdata(l1_rdata), .o_busy(l1_busy)
  );

  uf_bram_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(4), .STARVE_MAX(8)) u_l4 (
    .clk(clk), .rst(rst), .i_bram_ready(sw_ready), .o_enb(l4_enb), .o_addrb(l4_addrb), .i_doutb(zero_row),
    .i_r0_req(sw_r0_req), .i_r0_addr(sw_r0_addr), .o_r0_gnt(l4_g0), .o_r0_rvalid(l4_rv0),
    .i_r1_req(sw_r1_req), .i_r1_addr(sw_r1_addr), .o_r1_gnt(l4_g1), .o_r1_rvalid(l4_rv1),
    .o_rdata(l4_rdata), .o_busy(l4_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {160{8'hA5}} ^ {{(DW-AW){1'b0}}, a};
  endfunction

  // Two-cycle BRAM model for the main instance
  logic          e1, e2;
  logic [AW-1:0] a1, a2;
  always @(posedge clk) begin
    e1 <= enb;
    a1 <= addrb;
    e2 <= e1;
    a2 <= a1;
  end
  assign doutb = e2 ? pat(a2) : '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Starvation phase: both request from cycle 1 to 21, first serve cycle is 2
  function automatic bit eg1(input int c);
    return (c == 10) || (c == 19);
  endfunction
  function automatic bit eg0(input int c);
    return (c >= 2) && (c <= 21) && !eg1(c);
  endfunction

  localparam int NSW = 150;
  bit   hv  [0:NSW+8];
  bit   hid [0:NSW+8];
  logic g0, g1, pg0, pg1, ev, eid;
  logic [AW-1:0] ea;
  int   s;

  initial begin
    zero_row  = '0;
    rst       = 1'b1;
    ready     = 1'b0;
    r0_req    = 1'b1;
    r1_req    = 1'b1;
    r0_addr   = 9'h011;
    r1_addr   = 9'h1F0;
    sw_ready  = 1'b1;
    sw_r0_req = 1'b0;
    sw_r1_req = 1'b0;
    sw_r0_addr = '0;
    sw_r1_addr = '0;

    // Reset state
    cyc();
    cyc();
    #1;
    chk("rst_gnt",   {14'd0, r0_gnt, r1_gnt}, 16'd0);
    chk("rst_rv",    {14'd0, r0_rv, r1_rv}, 16'd0);
    chk("rst_enb",   {15'd0, enb}, 16'd0);
    chk("rst_addrb", {7'd0, addrb}, 16'd0);
    chk("rst_busy",  {15'd0, busy}, 16'd0);
    rst = 1'b0;

    // Gating: ready low, both requesting
    for (int i = 0; i < 20; i++) begin
      cyc();
      #1;
      chk("gate", {12'd0, r0_gnt, r1_gnt, enb, busy}, 16'd0);
    end

    // Ready rises; r0 gets the first grant, r1 forced every 9 cycles
    for (int c = 1; c <= 23; c++) begin
      cyc();
      ready  = 1'b1;
      r0_req = (c <= 21);
      r1_req = (c <= 21);
      #1;
      chk("starve_gnt", {14'd0, r0_gnt, r1_gnt}, {14'd0, 1'(eg0(c)), 1'(eg1(c))});
      chk("starve_rv",  {14'd0, r0_rv, r1_rv}, {14'd0, 1'(eg0(c-2)), 1'(eg1(c-2))});
      chk("starve_busy", {15'd0, busy}, {15'd0, 1'(c >= 2)});
      if (eg1(c)) chk("starve_addr", {7'd0, addrb}, 16'h01F0);
      if (eg1(c-2)) chk("starve_rdata", {15'd0, 1'(rdata === pat(9'h1F0))}, 16'd1);
    end

    // Basic read of row 5
    cyc();
    r0_req  = 1'b1;
    r0_addr = 9'h005;
    #1;
    chk("basic_gnt",   {13'd0, r0_gnt, r1_gnt, enb}, 16'b101);
    chk("basic_addrb", {7'd0, addrb}, 16'h0005);
    cyc();
    r0_req = 1'b0;
    #1;
    chk("basic_rv_early", {14'd0, r0_rv, r1_rv}, 16'd0);
    cyc();
    #1;
    chk("basic_rv",    {14'd0, r0_rv, r1_rv}, 16'b10);
    chk("basic_rdata", {15'd0, 1'(rdata === pat(9'h005))}, 16'd1);

    // Drain: two back-to-back reads then ready drops with r0 still asking
    cyc();
    r0_req  = 1'b1;
    r0_addr = 9'h020;
    #1;
    chk("drain_g1", {15'd0, r0_gnt}, 16'd1);
    cyc();
    r0_addr = 9'h021;
    #1;
    chk("drain_g2", {15'd0, r0_gnt}, 16'd1);
    cyc();
    ready = 1'b0;
    #1;
    chk("drain_nogrant0", {13'd0, r0_gnt, r1_gnt, enb}, 16'd0);
    chk("drain_rv0", {14'd0, r0_rv, busy}, 16'b11);
    cyc();
    #1;
    chk("drain_nogrant1", {13'd0, r0_gnt, r1_gnt, enb}, 16'd0);
    chk("drain_rv1", {14'd0, r0_rv, busy}, 16'b11);
    cyc();
    ready = 1'b1;
    #1;
    chk("drain_end", {13'd0, r0_rv, busy, enb}, 16'b010);
    cyc();
    #1;
    chk("drain_idle", {14'd0, busy, enb}, 16'd0);
    cyc();
    #1;
    chk("drain_reserve", {14'd0, busy, r0_gnt}, 16'b11);
    chk("drain_readdr", {7'd0, addrb}, 16'h0021);

    // Reset one cycle after a grant
    cyc();
    r0_req = 1'b0;
    rst    = 1'b1;
    #1;
    cyc();
    #1;
    chk("rstmid_rv",  {14'd0, r0_rv, r1_rv}, 16'd0);
    chk("rstmid_out", {13'd0, busy, enb, r0_gnt}, 16'd0);
    chk("rstmid_addrb", {7'd0, addrb}, 16'd0);
    rst = 1'b0;
    cyc();
    #1;
    chk("rstmid_rv2", {14'd0, r0_rv, r1_rv}, 16'd0);

    // Latency sweep against a reference arbitration model
    s   = 0;
    pg0 = 1'b0;
    pg1 = 1'b0;
    for (int c = 0; c < NSW + 6; c++) begin
      cyc();
      if (c < NSW) begin
        if (!sw_r0_req || pg0) begin
          sw_r0_req  = ($urandom_range(0, 3) != 0);
          sw_r0_addr = AW'($urandom_range(0, 511));
        end
        if (!sw_r1_req || pg1) begin
          sw_r1_req  = ($urandom_range(0, 1) != 0);
          sw_r1_addr = AW'($urandom_range(0, 511));
        end
      end else begin
        sw_r0_req = 1'b0;
        sw_r1_req = 1'b0;
      end
      g1 = sw_r1_req && ((s == 8) || !sw_r0_req);
      g0 = sw_r0_req && !g1;
      s  = (sw_r1_req && !g1) ? s + 1 : 0;
      ea = g1 ? sw_r1_addr : (g0 ? sw_r0_addr : '0);
      hv[c]  = g0 | g1;
      hid[c] = g1;
      pg0 = g0;
      pg1 = g1;
      #1;
      chk("sw_l1_gnt",  {6'd0, l1_g0, l1_g1, l1_addrb}, {6'd0, g0, g1, ea});
      chk("sw_l4_gnt",  {6'd0, l4_g0, l4_g1, l4_addrb}, {6'd0, g0, g1, ea});
      ev  = (c >= 1) ? hv[c-1] : 1'b0;
      eid = (c >= 1) ? hid[c-1] : 1'b0;
      chk("sw_l1_rv", {14'd0, l1_rv0, l1_rv1}, {14'd0, ev & !eid, ev & eid});
      ev  = (c >= 4) ? hv[c-4] : 1'b0;
      eid = (c >= 4) ? hid[c-4] : 1'b0;
      chk("sw_l4_rv", {14'd0, l4_rv0, l4_rv1}, {14'd0, ev & !eid, ev & eid});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
